// File: rtl/trim_length_ctrl_pkg.sv
// Shared encodings for the trim length controller: configuration modes and
// controller states, used by the RTL and its testbench.
package trim_length_ctrl_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] state_t;

  localparam mode_t MODE_QUEUE = 2'b00;
  localparam mode_t MODE_FIXED = 2'b01;
  localparam mode_t MODE_PASS  = 2'b10;

  localparam state_t ST_QUEUE = 2'd0;
  localparam state_t ST_FIXED = 2'd1;
  localparam state_t ST_PASS  = 2'd2;
  localparam state_t ST_FLUSH = 2'd3;

  // The reserved mode 2'b11 behaves exactly like PASS.
  function automatic state_t mode_to_state(input mode_t mode);
    case (mode)
      MODE_QUEUE: return ST_QUEUE;
      MODE_FIXED: return ST_FIXED;
      default:    return ST_PASS;
    endcase
  endfunction

endpackage

// File: rtl/trim_length_fifo.sv
// Length queue: circular buffer with a registered head word, occupancy count
// and a registered not-full flag so the writer never sees the reader's pop.
module trim_length_fifo #(
  parameter int WIDTH = 16,
  parameter int ITEMS = 16,
  localparam int AW = $clog2(ITEMS),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             not_full
);

  logic [WIDTH-1:0] mem [ITEMS];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    count_next;

  assign rd_next = rd_ptr + 1'b1;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  // The head register tracks the oldest word; a word pushed into an empty (or
  // just emptied) queue bypasses the array so it is visible the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      not_full <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_next;
      count    <= count_next;
      not_full <= (count_next != CW'(ITEMS));
      if (pop) begin
        if (count > CW'(1))
          head <= mem[rd_next];
        else if (push)
          head <= din;
      end else if (push && count == '0) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/trim_length_ctrl.sv
// Trim length controller: chooses between queued, fixed and pass-through
// lengths for the trimming unit and keeps served/underrun statistics.
module trim_length_ctrl
  import trim_length_ctrl_pkg::*;
#(
  parameter int LENGTH_WIDTH = 16,
  parameter int FIFO_ITEMS   = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LENGTH_WIDTH-1:0]     in_length,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic [1:0]                  cfg_mode,
  input  logic [LENGTH_WIDTH-1:0]     cfg_default_len,
  input  logic                        cfg_flush,
  output logic [LENGTH_WIDTH-1:0]     length,
  output logic                        length_ready,
  input  logic                        length_next,
  input  logic                        stat_clear,
  output logic [CNT_WIDTH-1:0]        stat_served,
  output logic [CNT_WIDTH-1:0]        stat_underrun,
  output logic [$clog2(FIFO_ITEMS):0] fifo_state
);

  state_t                      state;
  state_t                      state_next;
  logic                        fifo_clear;
  logic                        push;
  logic                        pop;
  logic                        not_full;
  logic [LENGTH_WIDTH-1:0]     head;
  logic [$clog2(FIFO_ITEMS):0] count;

  // A flush pulse blocks writes in its own cycle so nothing lands in the
  // queue that is about to be discarded.
  assign fifo_clear = cfg_flush || (state == ST_FLUSH);
  assign in_rdy     = not_full && !fifo_clear;
  assign push       = in_vld && in_rdy;
  assign pop        = (state == ST_QUEUE) && length_next && (count != '0);
  assign fifo_state = count;

  trim_length_fifo #(
    .WIDTH (LENGTH_WIDTH),
    .ITEMS (FIFO_ITEMS)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (fifo_clear),
    .push     (push),
    .din      (in_length),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .not_full (not_full)
  );

  // Mode changes wait for a cycle without a consume so the trimming unit never
  // sees the source switch under an in-flight handshake.
  always_comb begin
    state_next = state;
    if (cfg_flush)
      state_next = ST_FLUSH;
    else if (state == ST_FLUSH || !length_next)
      state_next = mode_to_state(cfg_mode);
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_QUEUE;
    else
      state <= state_next;
  end

  always_comb begin
    length       = head;
    length_ready = 1'b0;
    case (state)
      ST_QUEUE: length_ready = (count != '0);
      ST_FIXED: begin
        length       = cfg_default_len;
        length_ready = 1'b1;
      end
      ST_PASS: begin
        length       = '1;
        length_ready = 1'b1;
      end
      default: length_ready = 1'b0;
    endcase
  end

  // Counters saturate at all ones; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_served   <= '0;
      stat_underrun <= '0;
    end else if (length_next) begin
      if (length_ready && stat_served != '1)
        stat_served <= stat_served + 1'b1;
      if (!length_ready && stat_underrun != '1)
        stat_underrun <= stat_underrun + 1'b1;
    end
  end

endmodule

// File: doc/trim_length_ctrl.md
TRIM_LENGTH_CTRL -- requirements
Module: trim_length_ctrl

Interface
REQ-001 Parameter LENGTH_WIDTH, 16, width of one trim length word (matches the trimming unit LENGTH port).
REQ-002 Parameter FIFO_ITEMS, 16, length queue depth; power of two, 2..256.
REQ-003 Parameter CNT_WIDTH, 32, width of statistics counters.
REQ-004 CLK  in  1  single clock; all logic rising-edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 IN_LENGTH  in  LENGTH_WIDTH  length word from the classifier.
REQ-007 IN_VLD  in  1  IN_LENGTH valid.
REQ-008 IN_RDY  out  1  queue accepts a word; transfer when IN_VLD and IN_RDY.
REQ-009 CFG_MODE  in  2  00 QUEUE, 01 FIXED, 10 PASS, 11 reserved (treated as PASS).
REQ-010 CFG_DEFAULT_LEN  in  LENGTH_WIDTH  length presented in FIXED mode.
REQ-011 CFG_FLUSH  in  1  single-cycle pulse; discard queue contents.
REQ-012 LENGTH  out  LENGTH_WIDTH  length to trimming unit.
REQ-013 LENGTH_READY  out  1  LENGTH valid.
REQ-014 LENGTH_NEXT  in  1  trimming unit consumes LENGTH this cycle.
REQ-015 STAT_CLEAR  in  1  synchronous clear of both counters.
REQ-016 STAT_SERVED  out  CNT_WIDTH  lengths consumed.
REQ-017 STAT_UNDERRUN  out  CNT_WIDTH  LENGTH_NEXT seen while LENGTH_READY=0.
REQ-018 FIFO_STATE  out  log2(FIFO_ITEMS)+1  current queue occupancy.

Function
REQ-019 FSM states QUEUE, FIXED, PASS, FLUSH; state register drives all output muxing.
REQ-020 Mode transitions: CFG_MODE sampled each cycle; new mode state entered one cycle after CFG_MODE changes, only in a cycle where LENGTH_NEXT=0; if LENGTH_NEXT=1, switch deferred to next cycle with LENGTH_NEXT=0.
REQ-021 CFG_FLUSH=1 in any state -> FLUSH for exactly one cycle, then the state selected by CFG_MODE; flush overrides pending mode change.
REQ-022 In FLUSH: occupancy set to 0, IN_RDY=0, LENGTH_READY=0, IN_VLD ignored.
REQ-023 Queue: IN_RDY = not full, registered (no combinational path from LENGTH_NEXT); accepts writes in QUEUE, FIXED and PASS states.
REQ-024 QUEUE state: LENGTH = queue head, LENGTH_READY = occupancy>0; LENGTH_NEXT with LENGTH_READY pops head.
REQ-025 Latency: write accepted at cycle t into empty queue -> LENGTH_READY=1, LENGTH=word at t+1.
REQ-026 Simultaneous push and pop: occupancy unchanged, order preserved; when full IN_RDY=0 even if pop occurs same cycle.
REQ-027 FIXED state: LENGTH = CFG_DEFAULT_LEN (live), LENGTH_READY=1, queue not popped.
REQ-028 PASS state: LENGTH = all ones, LENGTH_READY=1, queue not popped.
REQ-029 STAT_SERVED +1 on LENGTH_NEXT and LENGTH_READY; STAT_UNDERRUN +1 on LENGTH_NEXT and not LENGTH_READY; both saturate at all ones.
REQ-030 STAT_CLEAR with simultaneous increment -> counter 0 (clear wins).
REQ-031 LENGTH value is unspecified while LENGTH_READY=0.

Reset
REQ-032 RESET=1 -> state QUEUE, occupancy 0, IN_RDY=0, LENGTH_READY=0, counters 0, FIFO_STATE=0; IN_RDY=1 first cycle after RESET deasserts.
REQ-033 RESET mid-operation discards queue contents and any pending mode change; no output depends on pre-reset data.

Structure
REQ-034 Package trim_length_ctrl_pkg holds mode encodings (QUEUE/FIXED/PASS) and FSM state enumeration, shared with testbench.
REQ-035 Queue storage and pointers in one sub-module trim_length_fifo (registered head output, occupancy, sync clear); FSM, muxing and counters in top.

Verification
REQ-036 QUEUE, push 100, 200, 300 on consecutive cycles, LENGTH_NEXT held 1 from cycle 4 -> LENGTH 100,200,300 on cycles 4-6, STAT_SERVED=3, FIFO_STATE 0.
REQ-037 Push FIFO_ITEMS words, no pops -> IN_RDY=0 after last write, FIFO_STATE=16; one pop -> IN_RDY=1 next cycle.
REQ-038 Queue holds 5, 6; CFG_MODE=FIXED with CFG_DEFAULT_LEN=64, 3 pops -> LENGTH=64 each, FIFO_STATE stays 2; back to QUEUE -> LENGTH=5.
REQ-039 Queue holds 4 words, CFG_FLUSH pulse with IN_VLD=1 -> IN_RDY=0 that cycle, FIFO_STATE=0 next cycle, LENGTH_READY=0, no word written.
REQ-040 Empty queue, LENGTH_NEXT=1 two cycles -> STAT_UNDERRUN=2; STAT_CLEAR with concurrent pop -> both counters 0.
REQ-041 RESET asserted with 3 queued words and mode change pending -> after release state QUEUE, FIFO_STATE=0, LENGTH_READY=0, counters 0.
